// File: rtl/ft245_sync_tx.sv
// ----------------------------------------------------------------------------
// ft245_sync_tx
//   Transmit (FPGA -> host) side of the FT232H FT245 synchronous FIFO
//   interface. Bytes from the controller are buffered in a small FIFO and
//   written to the FT232H with the ft_wr_n / ft_txe_n handshake. ft_bus is
//   shared with the receive path; an external arbiter grants it and the top
//   level builds the tristate from ft_data_oe.
//
//   Optional feature macro: FT_SIWU_EN
//     defined   : pulse ft_siwu_n low for one cycle after SIWU_IDLE idle cycles
//                 following a drain, so short packets are flushed at once.
//     undefined : ft_siwu_n is held at 1 and no idle counter exists.
//
// Ports
//   ft_clkout   in   60 MHz FT232H clock, sole clock
//   rst_n       in   synchronous active-low reset
//   s_data      in   byte to transmit
//   s_valid     in   s_data valid
//   s_ready     out  FIFO can accept a byte (registered)
//   bus_grant   in   arbiter grants ft_bus to this transmitter
//   tx_req      out  FIFO non-empty, bus wanted (registered)
//   ft_txe_n    in   FT232H transmit FIFO has space, active low
//   ft_wr_n     out  FT232H write strobe, active low
//   ft_data     out  byte driven onto ft_bus
//   ft_data_oe  out  top drives ft_bus from ft_data when high
//   ft_siwu_n   out  FT232H send-immediate, active low
//   fifo_count  out  bytes held in the FIFO
// ----------------------------------------------------------------------------
module ft245_sync_tx #(
    parameter int ADDR_W    = 4,
    parameter int SIWU_IDLE = 32
) (
    input  logic              ft_clkout,
    input  logic              rst_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              bus_grant,
    output logic              tx_req,
    input  logic              ft_txe_n,
    output logic              ft_wr_n,
    output logic [7:0]        ft_data,
    output logic              ft_data_oe,
    output logic              ft_siwu_n,
    output logic [ADDR_W:0]   fifo_count
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic              push, pop, wr_n_nxt;
    logic [ADDR_W:0]   remain, cnt_nxt;

    assign push    = s_valid & s_ready;
    // The FT232H takes a byte only when both strobes are low at the edge.
    assign pop     = ~ft_wr_n & ~ft_txe_n;
    assign rd_nxt  = rd_ptr + ADDR_W'(pop);
    // Bytes still buffered once this edge's pop is accounted for. A byte
    // pushed at this edge is excluded: it is not in memory yet, so it cannot
    // be presented on ft_data at the next cycle.
    assign remain  = fifo_count - (ADDR_W+1)'(pop);
    assign cnt_nxt = remain + (ADDR_W+1)'(push);

    always_comb begin
        state_nxt = state;
        wr_n_nxt  = 1'b1;
        case (state)
            S_IDLE: begin
                if (bus_grant && tx_req) state_nxt = S_ARM;
            end
            S_ARM: begin
                // ARM is the bus-turnaround cycle: data driven, strobe high.
                if (bus_grant) begin
                    state_nxt = S_WRITE;
                    wr_n_nxt  = ~(~ft_txe_n & (remain != '0));
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                // Leaving always lands with the strobe high; a byte strobed
                // at this edge is still consumed if ft_txe_n is low.
                if (!bus_grant || remain == '0) state_nxt = S_IDLE;
                else                            wr_n_nxt  = ft_txe_n;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ft_clkout) begin
        if (rst_n && push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge ft_clkout) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            s_ready    <= 1'b0;
            tx_req     <= 1'b0;
            ft_wr_n    <= 1'b1;
            ft_data    <= 8'h00;
            ft_data_oe <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr     <= rd_nxt;
            fifo_count <= cnt_nxt;
            s_ready    <= (cnt_nxt < DEPTH_C);
            tx_req     <= (cnt_nxt != '0);
            ft_wr_n    <= wr_n_nxt;
            ft_data_oe <= (state_nxt != S_IDLE);
            // Head after this edge's pop; only loaded while the bus is ours,
            // where the entry is guaranteed to hold valid data.
            if (state_nxt != S_IDLE) ft_data <= mem[rd_nxt];
        end
    end

`ifdef FT_SIWU_EN
    localparam int CW = (SIWU_IDLE > 1) ? $clog2(SIWU_IDLE) : 1;

    logic [CW-1:0] idle_cnt;
    logic          sent;

    // Idle cycles are counted only after traffic since the last pulse, with
    // the FIFO empty and the bus released (ft_wr_n is 1 in IDLE).
    always_ff @(posedge ft_clkout) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            sent      <= 1'b0;
            ft_siwu_n <= 1'b1;
        end else begin
            ft_siwu_n <= 1'b1;
            if (pop) sent <= 1'b1;
            if (push) begin
                idle_cnt <= '0;
            end else if (state == S_IDLE && fifo_count == '0 && sent) begin
                if (idle_cnt == CW'(SIWU_IDLE - 1)) begin
                    ft_siwu_n <= 1'b0;
                    idle_cnt  <= '0;
                    sent      <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_siwu;
    assign unused_siwu = ^SIWU_IDLE;
    assign ft_siwu_n   = 1'b1;
`endif

endmodule

// File: doc/ft245_sync_tx.md
Name: ft245_sync_tx

Overview:
- Transmit (FPGA -> host) side of the FT232H FT245 synchronous FIFO interface, clocked by the 60 MHz ft_clkout.
- Buffers bytes from the controller (readout pixels, register read-backs, status) in a small FIFO and writes them to the FT232H with the ft_wr_n / ft_txe_n handshake.
- Shares ft_bus with the receive path. A top-level arbiter grants the bus, and top builds the tristate from ft_data_oe.

Parameters:
- ADDR_W, 4, FIFO depth = 2**ADDR_W bytes.
- SIWU_IDLE, 32, idle ft_clkout cycles after drain before the send-immediate pulse (FT_SIWU_EN only).

Ports:
- ft_clkout  in  1  60 MHz FT232H clock; sole clock.
- rst_n  in  1  synchronous, active-low reset.
- s_data  in  8  byte to transmit.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept a byte.
- bus_grant  in  1  arbiter grants ft_bus to transmitter.
- tx_req  out  1  FIFO non-empty, bus wanted.
- ft_txe_n  in  1  FT232H transmit FIFO has space, active low.
- ft_wr_n  out  1  FT232H write strobe, active low.
- ft_data  out  8  byte driven onto ft_bus.
- ft_data_oe  out  1  top drives ft_bus from ft_data when high.
- ft_siwu_n  out  1  FT232H send-immediate, active low.
- fifo_count  out  ADDR_W+1  bytes held.

Behaviour:
Reset:
- When rst_n is low at a rising edge: s_ready=0, tx_req=0, ft_wr_n=1, ft_data=0, ft_data_oe=0, ft_siwu_n=1, fifo_count=0.
- FIFO is emptied and pointers cleared. Reset mid-burst discards buffered bytes.
- s_ready=1 from the first edge after rst_n goes high.

Input side:
- Push when s_valid & s_ready at an edge.
- s_ready = (fifo_count < 2**ADDR_W), registered.
- A push and a pop at the same edge leave the count unchanged.
- A push when full is impossible (s_ready=0).
- tx_req = (fifo_count != 0), registered.

Consume rule:
- A byte is taken by the FT232H only at a rising edge where ft_wr_n==0 AND ft_txe_n==0.
- Only that condition pops the FIFO.

FSM, all outputs registered:
- IDLE:
  - ft_data_oe=0, ft_wr_n=1.
  - -> ARM when bus_grant & tx_req.
- ARM:
  - ft_data_oe=1, ft_data = FIFO head, ft_wr_n=1. This gives one bus-turnaround cycle.
  - -> WRITE when bus_grant.
  - -> IDLE if bus_grant has dropped.
- WRITE:
  - ft_wr_n = !(bus_grant & !ft_txe_n & bytes remaining after this edge's pop).
  - ft_data always equals the current FIFO head while ft_wr_n=0. After a pop it shows the next byte on the following cycle, so a continuous burst runs at 1 byte/cycle.
  - ft_txe_n high: ft_wr_n deasserts at the next edge. A byte presented while ft_txe_n was high is not popped and stays on ft_data for retry.
  - -> IDLE when the FIFO drains, or when bus_grant is low, in both cases with ft_wr_n already 1.
- Grant dropped with ft_wr_n=0 at that edge:
  - the byte is still consumed if ft_txe_n==0;
  - ft_wr_n=1 and ft_data_oe=0 on the next edge.
- Invariants:
  - ft_wr_n is never 0 while ft_data_oe=0.
  - ft_data_oe never drops in the same cycle that ft_wr_n goes 1->0.

Arithmetic:
- Pointers are ADDR_W bits and wrap modulo depth.
- fifo_count is ADDR_W+1 bits and saturates nowhere; it is bounded by flow control.

Optional Feature:
FT_SIWU_EN
- Defined:
  - An idle counter runs while the FIFO is empty, state is IDLE, and at least one byte has been sent since the last pulse.
  - At SIWU_IDLE cycles, ft_siwu_n pulses low for exactly 1 cycle. The host gets a short packet flushed instead of waiting on the FT232H latency timer.
  - Any push clears the counter.
  - No pulse is issued while ft_wr_n=0.
- Undefined: ft_siwu_n is tied to 1 and no counter logic exists.

Test Plan:
- Reset and hold: rst_n=0 for 3 cycles with s_valid=1 -> all outputs at reset values; fifo_count=0 after release; nothing was pushed during reset.
- Burst write: push 0x11,0x22,0x33; bus_grant=1; ft_txe_n=0 -> one ARM cycle, then ft_wr_n low for exactly 3 consecutive cycles; FT model captures 0x11,0x22,0x33 in order; ft_data_oe falls after; fifo_count=0.
- TXE stall: push 0xA0..0xA3; raise ft_txe_n for 5 cycles after 0xA1 is consumed -> no pop while ft_txe_n high; 0xA2 retried and captured once; total captured 0xA0,0xA1,0xA2,0xA3 with no duplicates or losses.
- Full/flow control: ADDR_W=4, bus_grant=0, push 20 bytes -> s_ready low after 16; fifo_count=16; grant then drains all 16 in order, and s_ready returns high 1 cycle after the first pop.
- Grant revoke mid-burst: 8 bytes queued, drop bus_grant after 3 consumed -> ft_wr_n=1 and ft_data_oe=0 within 1 cycle; re-grant resumes at the 4th byte.
- FT_SIWU_EN, SIWU_IDLE=32: send 1 byte, then idle -> ft_siwu_n low for 1 cycle exactly 32 cycles after drain; no second pulse without new traffic. Without the macro, ft_siwu_n stays 1.
